// File: rtl/axilite_pkg.sv
// Shared types for the AXI4-Lite command master.
//   resp_t      : AXI BRESP/RRESP encoding
//   mst_state_t : command master sequencing states
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
package axilite_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RESP
   } mst_state_t;

endpackage

// File: rtl/axilite_watchdog.sv
// Per-transaction watchdog for the AXI4-Lite command master.
//   clk_sys, rst_b : clock, async active-low reset
//   clr            : restart the count (command accept)
//   en             : count this cycle (transaction in flight)
//   expire         : count has reached TIMEOUT-1 while enabled
// The count saturates at TIMEOUT so a transaction that slips past its
// expiry edge on a same-edge handshake can never wrap and re-trigger.
// TIMEOUT = 0 disables expiry altogether.
module axilite_watchdog #(
   parameter int TIMEOUT = 256
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != SAT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (TIMEOUT != 0) && en && (cnt_q == TERM);

endmodule

// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
//   cmd_*   : command in (write/read, addr, wdata, wstrb); cmd_ready = idle
//   rsp_*   : response out (rdata, err, timeout), held until rsp_ready
//   AXI_*   : AXI4-Lite master interface (AW, W, B, AR, R channels)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// WR_REQ  | AWVALID/WVALID up, each drops on its own handshake
// WR_RESP | BREADY held high, waiting for BVALID
// RD_ADDR | ARVALID held until ARREADY
// RD_DATA | RREADY held high, waiting for RVALID
// RESP    | rsp_valid high until rsp_ready
module axilite_cmd_master
   import axilite_pkg::*;
#(
   parameter int ADDR_W  = axilite_pkg::ADDR_W_DEF,
   parameter int DATA_W  = axilite_pkg::DATA_W_DEF,
   parameter int TIMEOUT = 256
) (
   input  logic                AXI_ACLK,
   input  logic                AXI_ARESETN,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic [ADDR_W-1:0]   AXI_AWADDR,
   output logic                AXI_AWVALID,
   input  logic                AXI_AWREADY,
   output logic [DATA_W-1:0]   AXI_WDATA,
   output logic [DATA_W/8-1:0] AXI_WSTRB,
   output logic                AXI_WVALID,
   input  logic                AXI_WREADY,
   input  logic [1:0]          AXI_BRESP,
   input  logic                AXI_BVALID,
   output logic                AXI_BREADY,
   output logic [ADDR_W-1:0]   AXI_ARADDR,
   output logic                AXI_ARVALID,
   input  logic                AXI_ARREADY,
   input  logic [DATA_W-1:0]   AXI_RDATA,
   input  logic [1:0]          AXI_RRESP,
   input  logic                AXI_RVALID,
   output logic                AXI_RREADY
);

   mst_state_t          state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                arvalid_q, arvalid_d, rready_q, rready_d;
   logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic cmd_acc, wd_en, wd_expire, abort, aw_done, w_done;

   assign cmd_ready = (state_q == IDLE);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign wd_en     = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_ADDR) || (state_q == RD_DATA);
   // A channel counts as done once its handshake is sampled or was already taken.
   assign aw_done   = !awvalid_q || AXI_AWREADY;
   assign w_done    = !wvalid_q  || AXI_WREADY;

   axilite_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk_sys (AXI_ACLK),
      .rst_b   (AXI_ARESETN),
      .clr     (cmd_acc),
      .en      (wd_en),
      .expire  (wd_expire)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      abort         = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end
         WR_REQ: begin
            if (aw_done && w_done) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
               bready_d  = 1'b1;
               state_d   = WR_RESP;
            end else if (wd_expire) begin
               abort = 1'b1;
            end else begin
               if (AXI_AWREADY) awvalid_d = 1'b0;
               if (AXI_WREADY)  wvalid_d  = 1'b0;
            end
         end
         WR_RESP: begin
            if (AXI_BVALID) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = (resp_t'(AXI_BRESP) != OKAY);
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end else if (wd_expire) begin
               abort = 1'b1;
            end
         end
         RD_ADDR: begin
            if (AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end else if (wd_expire) begin
               abort = 1'b1;
            end
         end
         RD_DATA: begin
            if (AXI_RVALID) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = AXI_RDATA;
               rsp_err_d     = (resp_t'(AXI_RRESP) != OKAY);
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end else if (wd_expire) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_rdata_d   = '0;
         rsp_err_d     = 1'b1;
         rsp_timeout_d = 1'b1;
         state_d       = RESP;
      end
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign AXI_AWADDR  = addr_q;
   assign AXI_ARADDR  = addr_q;
   assign AXI_WDATA   = wdata_q;
   assign AXI_WSTRB   = wstrb_q;
   assign AXI_AWVALID = awvalid_q;
   assign AXI_WVALID  = wvalid_q;
   assign AXI_BREADY  = bready_q;
   assign AXI_ARVALID = arvalid_q;
   assign AXI_RREADY  = rready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
